// File: rtl/r408_pkg.sv
// Shared constants and state encodings for the R408 D-bus UART.
package r408_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIVL = 2'd2;
  localparam logic [1:0] REG_DIVH = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RXOVR    = 3;
  localparam int ST_FERR     = 4;
  localparam int ST_TXOVF    = 5;
  localparam int ST_IE_RX    = 6;
  localparam int ST_IE_TX    = 7;

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK} bus_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // Shorter bit periods leave no room for the half-bit start check.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd3) ? 16'd3 : d;
  endfunction

endpackage

// File: rtl/r408_sync_fifo.sv
// Single-clock FIFO, registered pointers, combinational head; push into a full FIFO
// is accepted only when a pop happens in the same cycle, otherwise it is ignored.
module r408_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    dout    = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/r408_dbus_uart.sv
// D-bus UART: 4-byte register window, 8N1 TX/RX with FIFOs; rdy after WAIT_CYCLES+1 clocks,
// full FIFOs drop bytes and raise sticky flags. Define R408_UART_IRQ_EN for the irq output.
module r408_dbus_uart
  import r408_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'hFF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] DIV_RESET   = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        write,
  input  logic        read,
  output logic        rdy,
  output logic        txd,
  input  logic        rxd
`ifdef R408_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e  bst_q, bst_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] div_q, div_d;
  logic        txovf_q, txovf_d, rxovr_q, rxovr_d, ferr_q, ferr_d;
  logic        ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d, irq_q, irq_d;

  tx_state_e   tst_q, tst_d;
  logic [15:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d;
  logic [2:0]  tbit_q, tbit_d;
  logic [7:0]  tsh_q, tsh_d;
  logic        txd_q, txd_d;

  rx_state_e   rst_q, rst_d;
  logic [15:0] rcnt_q, rcnt_d, rdiv_q, rdiv_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        rwait_q, rwait_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  logic        hit, sel, ack_go, is_wr;
  logic [1:0]  off;
  logic        cpu_push, cpu_pop, stat_wr;
  logic        tx_full, tx_empty, tx_pop, tx_launch, tx_idle;
  logic [7:0]  tx_dout;
  logic        rx_full, rx_empty, rx_push, ferr_set;
  logic [7:0]  rx_dout;
  logic [7:0]  status;
  logic [15:0] div_eff, half_bit;

  r408_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(cpu_push), .pop(tx_pop), .din(wdata),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  r408_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(cpu_pop), .din(rsh_q),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign div_eff  = eff_div(div_q);
  assign half_bit = {1'b0, div_eff[15:1]} + {15'd0, div_eff[0]};
  assign tx_idle  = (tst_q == T_IDLE) & tx_empty;

  always_comb begin
    status              = 8'h00;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_IDLE]  = tx_idle;
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RXOVR]    = rxovr_q;
    status[ST_FERR]     = ferr_q;
    status[ST_TXOVF]    = txovf_q;
`ifdef R408_UART_IRQ_EN
    status[ST_IE_RX]    = ie_rx_q;
    status[ST_IE_TX]    = ie_tx_q;
`endif
  end

  // Bus handshake; the core holds addr/wdata until rdy, so they are decoded live at ack time.
  always_comb begin
    hit    = (addr[15:2] == BASE[15:2]);
    sel    = (read | write) & hit;
    is_wr  = write;
    off    = addr[1:0];
    bst_d  = bst_q;
    wcnt_d = wcnt_q;
    ack_go = 1'b0;
    case (bst_q)
      B_IDLE: if (sel) begin
        if (WAIT_CYCLES > 0) begin
          bst_d  = B_WAIT;
          wcnt_d = WAIT_INIT;
        end else begin
          bst_d  = B_ACK;
          ack_go = 1'b1;
        end
      end
      B_WAIT: if (wcnt_q == 4'd0) begin
        bst_d  = B_ACK;
        ack_go = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
      default: bst_d = B_IDLE;
    endcase

    cpu_push = ack_go & is_wr & (off == REG_DATA);
    cpu_pop  = ack_go & ~is_wr & (off == REG_DATA);
    stat_wr  = ack_go & is_wr & (off == REG_STAT);
    rdy_d    = ack_go;
    rdata_d  = 8'h00;
    if (ack_go && !is_wr) begin
      case (off)
        REG_DATA: rdata_d = rx_empty ? 8'h00 : rx_dout;
        REG_STAT: rdata_d = status;
        REG_DIVL: rdata_d = div_q[7:0];
        default:  rdata_d = div_q[15:8];
      endcase
    end

    div_d = div_q;
    if (ack_go && is_wr && off == REG_DIVL) div_d[7:0]  = wdata;
    if (ack_go && is_wr && off == REG_DIVH) div_d[15:8] = wdata;
  end

  // Sticky flags: a new event in the same cycle as a clear wins.
  always_comb begin
    txovf_d = txovf_q;
    rxovr_d = rxovr_q;
    ferr_d  = ferr_q;
    ie_rx_d = ie_rx_q;
    ie_tx_d = ie_tx_q;
    if (stat_wr) begin
      if (wdata[ST_TXOVF]) txovf_d = 1'b0;
      if (wdata[ST_RXOVR]) rxovr_d = 1'b0;
      if (wdata[ST_FERR])  ferr_d  = 1'b0;
`ifdef R408_UART_IRQ_EN
      ie_rx_d = wdata[ST_IE_RX];
      ie_tx_d = wdata[ST_IE_TX];
`endif
    end
    if (cpu_push && tx_full && !tx_pop)                  txovf_d = 1'b1;
    if (rx_push && rx_full && !(cpu_pop && !rx_empty))   rxovr_d = 1'b1;
    if (ferr_set)                                        ferr_d  = 1'b1;
    irq_d = (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_idle) | rxovr_q | ferr_q;
  end

  always_comb begin
    tst_d     = tst_q;
    tcnt_d    = tcnt_q;
    tdiv_d    = tdiv_q;
    tbit_d    = tbit_q;
    tsh_d     = tsh_q;
    txd_d     = txd_q;
    tx_pop    = 1'b0;
    tx_launch = 1'b0;
    case (tst_q)
      T_IDLE:  tx_launch = ~tx_empty;
      T_START: if (tcnt_q == 16'd0) begin
        tst_d  = T_DATA;
        tcnt_d = tdiv_q;
        tbit_d = 3'd0;
        txd_d  = tsh_q[0];
      end else begin
        tcnt_d = tcnt_q - 16'd1;
      end
      T_DATA: if (tcnt_q == 16'd0) begin
        tcnt_d = tdiv_q;
        tsh_d  = tsh_q >> 1;
        if (tbit_q == 3'd7) begin
          tst_d = T_STOP;
          txd_d = 1'b1;
        end else begin
          tbit_d = tbit_q + 3'd1;
          txd_d  = tsh_q[1];
        end
      end else begin
        tcnt_d = tcnt_q - 16'd1;
      end
      default: if (tcnt_q == 16'd0) begin
        tst_d     = T_IDLE;
        tx_launch = ~tx_empty;
      end else begin
        tcnt_d = tcnt_q - 16'd1;
      end
    endcase
    // The divisor is captured here so a frame in flight keeps its bit period.
    if (tx_launch) begin
      tx_pop = 1'b1;
      tst_d  = T_START;
      tsh_d  = tx_dout;
      tdiv_d = div_eff;
      tcnt_d = div_eff;
      txd_d  = 1'b0;
    end
  end

  always_comb begin
    rst_d    = rst_q;
    rcnt_d   = rcnt_q;
    rdiv_d   = rdiv_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rwait_d  = rwait_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    case (rst_q)
      R_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rst_d  = R_START;
        rdiv_d = div_eff;
        rcnt_d = half_bit - 16'd1;
      end
      R_START: if (rcnt_q == 16'd0) begin
        if (rx_s2_q) begin
          rst_d = R_IDLE;
        end else begin
          rst_d  = R_DATA;
          rcnt_d = rdiv_q;
          rbit_d = 3'd0;
        end
      end else begin
        rcnt_d = rcnt_q - 16'd1;
      end
      R_DATA: if (rcnt_q == 16'd0) begin
        rsh_d  = {rx_s2_q, rsh_q[7:1]};
        rcnt_d = rdiv_q;
        if (rbit_q == 3'd7) rst_d = R_STOP;
        else                rbit_d = rbit_q + 3'd1;
      end else begin
        rcnt_d = rcnt_q - 16'd1;
      end
      default: if (rwait_q) begin
        if (rx_s2_q) begin
          rst_d   = R_IDLE;
          rwait_d = 1'b0;
        end
      end else if (rcnt_q == 16'd0) begin
        if (rx_s2_q) begin
          rx_push = 1'b1;
          rst_d   = R_IDLE;
        end else begin
          ferr_set = 1'b1;
          rwait_d  = 1'b1;
        end
      end else begin
        rcnt_d = rcnt_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bst_q     <= B_IDLE;
      wcnt_q    <= 4'd0;
      rdy_q     <= 1'b0;
      rdata_q   <= 8'h00;
      div_q     <= DIV_RESET;
      txovf_q   <= 1'b0;
      rxovr_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ie_rx_q   <= 1'b0;
      ie_tx_q   <= 1'b0;
      irq_q     <= 1'b0;
      tst_q     <= T_IDLE;
      tcnt_q    <= 16'd0;
      tdiv_q    <= 16'd0;
      tbit_q    <= 3'd0;
      tsh_q     <= 8'h00;
      txd_q     <= 1'b1;
      rst_q     <= R_IDLE;
      rcnt_q    <= 16'd0;
      rdiv_q    <= 16'd0;
      rbit_q    <= 3'd0;
      rsh_q     <= 8'h00;
      rwait_q   <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      bst_q     <= bst_d;
      wcnt_q    <= wcnt_d;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
      div_q     <= div_d;
      txovf_q   <= txovf_d;
      rxovr_q   <= rxovr_d;
      ferr_q    <= ferr_d;
      ie_rx_q   <= ie_rx_d;
      ie_tx_q   <= ie_tx_d;
      irq_q     <= irq_d;
      tst_q     <= tst_d;
      tcnt_q    <= tcnt_d;
      tdiv_q    <= tdiv_d;
      tbit_q    <= tbit_d;
      tsh_q     <= tsh_d;
      txd_q     <= txd_d;
      rst_q     <= rst_d;
      rcnt_q    <= rcnt_d;
      rdiv_q    <= rdiv_d;
      rbit_q    <= rbit_d;
      rsh_q     <= rsh_d;
      rwait_q   <= rwait_d;
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rdy   = rdy_q;
  assign rdata = rdata_q;
  assign txd   = txd_q;
`ifdef R408_UART_IRQ_EN
  assign irq   = irq_q;
`endif

endmodule

// File: tb/tb_r408_dbus_uart.sv
// Directed bench for r408_dbus_uart: bus access, TX framing, loopback RX, overflow, glitch/FERR, wait states.
module tb_r408_dbus_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        write = 1'b0, read = 1'b0;
  logic [7:0]  rdata;
  logic        rdy, txd;
  logic        rxd_drv = 1'b1, loop_en = 1'b0;
  logic        rxd;
  logic        rd_w = 1'b0;
  logic [7:0]  rdata_w;
  logic        rdy_w, txd_w;
`ifdef R408_UART_IRQ_EN
  logic        irq0, irq1;
`endif

  int errors = 0;
  int checks = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  r408_dbus_uart #(.BASE(16'hFF00), .FIFO_DEPTH(4), .WAIT_CYCLES(0), .DIV_RESET(16'd433)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata), .write(write),
    .read(read), .rdy(rdy), .txd(txd), .rxd(rxd)
`ifdef R408_UART_IRQ_EN
    , .irq(irq0)
`endif
  );

  r408_dbus_uart #(.BASE(16'hFF00), .FIFO_DEPTH(4), .WAIT_CYCLES(3), .DIV_RESET(16'd433)) dut_w (
    .clk(clk), .rst(rst), .addr(16'hFF00), .wdata(8'h00), .rdata(rdata_w), .write(1'b0),
    .read(rd_w), .rdy(rdy_w), .txd(txd_w), .rxd(1'b1)
`ifdef R408_UART_IRQ_EN
    , .irq(irq1)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One bus access on the main DUT, called at a negedge; returns data and latency in cycles.
  task automatic bus(input logic wr, input logic [1:0] off, input logic [7:0] d,
                     output logic [7:0] rd, output int lat);
    logic got;
    got   = 1'b0;
    rd    = 8'h00;
    lat   = 0;
    addr  = {14'h3FC0, off};
    wdata = d;
    write = wr;
    read  = ~wr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rdy) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_timeout off=%0d got no rdy within 40 cycles, required rdy", off);
    end
    write = 1'b0;
    read  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int lat;
    repeat (3) @(negedge clk);
    checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
    checks++; if (rdata !== 8'h00)  begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    checks++; if (txd !== 1'b1)     begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    rst = 1'b1;
    @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL reset_status got %h want 02", rd); end
    checks++; if (lat != 1)     begin errors++; $display("FAIL reset_latency got %0d want 1", lat); end
  endtask

  task automatic test_tx();
    logic [7:0] rd;
    logic [9:0] exp_bits;
    logic       bad;
    int lat, n;
    exp_bits = 10'b11_0100_1010;
    bus(1'b1, 2'd2, 8'h03, rd, lat);
    bus(1'b1, 2'd3, 8'h00, rd, lat);
    bus(1'b0, 2'd2, 8'h00, rd, lat);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL div_lo_readback got %h want 03", rd); end
    bus(1'b1, 2'd0, 8'hA5, rd, lat);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      bad = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (txd !== exp_bits[i]) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) begin errors++; $display("FAIL tx_bit%0d got unstable/wrong want %b for 4 clocks", i, exp_bits[i]); end
    end
    repeat (4) @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL tx_idle_status got %h want 02", rd); end
  endtask

  task automatic test_loopback();
    logic [7:0] rd;
    int lat;
    loop_en = 1'b1;
    bus(1'b1, 2'd0, 8'h3C, rd, lat);
    repeat (70) @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h06) begin errors++; $display("FAIL loop_status got %h want 06", rd); end
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL loop_data got %h want 3c", rd); end
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL loop_status_after got %h want 02", rd); end
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h want 00", rd); end
    loop_en = 1'b0;
  endtask

  // The serialiser takes the first byte, so four more fill the FIFO and the sixth is dropped.
  task automatic test_txovf();
    logic [7:0] rd;
    int lat;
    bus(1'b1, 2'd2, 8'hFF, rd, lat);
    bus(1'b1, 2'd3, 8'hFF, rd, lat);
    for (int i = 0; i < 5; i++) bus(1'b1, 2'd0, 8'(8'h10 + i), rd, lat);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL txfifo_full got %h want 01", rd); end
    bus(1'b1, 2'd0, 8'h99, rd, lat);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h21) begin errors++; $display("FAIL txovf_set got %h want 21", rd); end
    bus(1'b1, 2'd1, 8'h20, rd, lat);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL txovf_clear got %h want 01", rd); end
  endtask

  task automatic send_bit(input logic b);
    rxd_drv = b;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_rx_errors();
    logic [7:0] rd;
    logic [7:0] byte_v;
    int lat;
    bus(1'b1, 2'd2, 8'h07, rd, lat);
    bus(1'b1, 2'd3, 8'h00, rd, lat);
    rxd_drv = 1'b0;
    @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL glitch_status got %h want 01", rd); end
    byte_v = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
    send_bit(1'b0);
    send_bit(1'b0);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL ferr_status got %h want 11", rd); end
    bus(1'b1, 2'd1, 8'h10, rd, lat);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL ferr_clear got %h want 01", rd); end
  endtask

  task automatic test_wait();
    logic got;
    int lat;
    got  = 1'b0;
    lat  = 0;
    rd_w = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rdy_w) got = 1'b1;
    end
    checks++; if (lat != 4 || !got) begin errors++; $display("FAIL wait_latency got %0d (rdy=%b) want 4", lat, got); end
    checks++; if (rdata_w !== 8'h00) begin errors++; $display("FAIL wait_rdata got %h want 00", rdata_w); end
    rd_w = 1'b0;
    @(negedge clk);
    checks++; if (rdy_w !== 1'b0 || rdata_w !== 8'h00) begin
      errors++; $display("FAIL wait_rdy_one_cycle got rdy=%b rdata=%h want 0/00", rdy_w, rdata_w);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int lat;
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midframe_txd got %b want 0", txd); end
    rst = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_async_txd got %b want 1", txd); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL post_reset_status got %h want 02", rd); end
    bus(1'b0, 2'd2, 8'h00, rd, lat);
    checks++; if (rd !== 8'hB1) begin errors++; $display("FAIL post_reset_divlo got %h want b1", rd); end
    bus(1'b0, 2'd3, 8'h00, rd, lat);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL post_reset_divhi got %h want 01", rd); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_loopback();
    test_txovf();
    test_rx_errors();
    test_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
